// File: rtl/pcap_axis_deframer.sv
// pcap_axis_deframer: strips the 2-word PCAP record header and serialises the payload onto 8-bit AXIS.
// Optional build macro PCAP_DEFRAMER_LEN_CHECK_EN adds a byte-count vs frame-length check (err_len_mismatch).
module pcap_axis_deframer #(
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int KEEP_WIDTH      = AXI_DATA_WIDTH / 8,
    parameter int AXIS_USER_WIDTH = 1,
    parameter int FRAME_LEN_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXI_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    output logic [31:0]                hdr_ts_sec,
    output logic [31:0]                hdr_ts_nsec,
    output logic [FRAME_LEN_WIDTH-1:0] hdr_frame_len,
    output logic                       hdr_valid,
    output logic                       err_truncated,
    output logic [31:0]                frame_count
`ifdef PCAP_DEFRAMER_LEN_CHECK_EN
    ,
    output logic                       err_len_mismatch
`endif
);

    typedef enum logic [1:0] {ST_TS, ST_LEN, ST_PAYLOAD} state_t;

    localparam logic [FRAME_LEN_WIDTH-1:0] CNT_MAX = '1;

    state_t state_q, state_d;

    logic [AXI_DATA_WIDTH-1:0]  hold_data_q;
    logic [KEEP_WIDTH-1:0]      hold_keep_q;
    logic                       hold_last_q;
    logic                       hold_user_q;
    logic                       hold_vld_q;
    logic [AXI_DATA_WIDTH-1:0]  ts_stage_q;
    logic [AXI_DATA_WIDTH-1:0]  hdr_ts_q;
    logic [FRAME_LEN_WIDTH-1:0] hdr_len_q;
    logic [FRAME_LEN_WIDTH-1:0] byte_cnt_q;
    logic [FRAME_LEN_WIDTH-1:0] byte_cnt_inc;
    logic                       hdr_valid_q;
    logic                       err_trunc_q;
    logic [31:0]                frame_cnt_q;

    logic                  s_ready;
    logic                  s_hs;
    logic                  load_ts;
    logic                  load_hdr;
    logic                  load_hold;
    logic                  trunc;
    logic [KEEP_WIDTH-1:0] low_bit;
    logic [KEEP_WIDTH-1:0] rest;
    logic                  byte_avail;
    logic                  marker;
    logic                  m_hs;
    logic                  final_lane;
    logic                  final_hs;
    logic                  last_byte;
    logic                  close_byte;
    logic                  close_marker;
    logic                  trunc_marker;
    logic [7:0]            m_byte;

    // Remaining lanes of the held word are tracked as a shrinking keep mask;
    // a held word with an empty mask is a tlast-only marker closing the record.
    assign low_bit      = hold_keep_q & (~hold_keep_q + KEEP_WIDTH'(1));
    assign rest         = hold_keep_q & ~low_bit;
    assign byte_avail   = hold_vld_q & (|hold_keep_q);
    assign marker       = hold_vld_q & ~(|hold_keep_q);
    assign final_lane   = ~(|rest);
    assign m_hs         = byte_avail & m_axis_tready;
    assign final_hs     = m_hs & final_lane;
    assign last_byte    = byte_avail & final_lane & hold_last_q;
    assign close_byte   = final_hs & hold_last_q;
    assign close_marker = marker & (byte_cnt_q != '0);
    assign trunc_marker = marker & (byte_cnt_q == '0);
    assign byte_cnt_inc = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + 1'b1;
    assign s_axis_tready = s_ready & ~rst;
    assign s_hs          = s_axis_tvalid & s_axis_tready;

    // Select the lowest still-pending lane of the held word.
    always_comb begin
        m_byte = '0;
        for (int i = KEEP_WIDTH - 1; i >= 0; i--) begin
            if (hold_keep_q[i]) begin
                m_byte = hold_data_q[i*8 +: 8];
            end
        end
    end

    // Next-state and per-cycle control for the header/payload sequencer.
    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        load_ts   = 1'b0;
        load_hdr  = 1'b0;
        load_hold = 1'b0;
        trunc     = 1'b0;
        unique case (state_q)
            ST_TS: begin
                s_ready = 1'b1;
                if (s_hs) begin
                    if (s_axis_tlast) begin
                        trunc = 1'b1;
                    end else begin
                        load_ts = 1'b1;
                        state_d = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                s_ready = 1'b1;
                if (s_hs) begin
                    state_d = s_axis_tlast ? ST_TS : ST_PAYLOAD;
                    trunc    = s_axis_tlast;
                    load_hdr = ~s_axis_tlast;
                end
            end
            ST_PAYLOAD: begin
                // Never pull in the next record's header while a tlast word drains.
                s_ready   = ~hold_vld_q | (final_hs & ~hold_last_q);
                load_hold = s_hs & ((|s_axis_tkeep) | s_axis_tlast);
                trunc     = trunc_marker;
                if (close_byte | close_marker | trunc_marker) begin
                    state_d = ST_TS;
                end
            end
            default: state_d = ST_TS;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_TS;
        else     state_q <= state_d;
    end

    // Payload hold register: loaded per accepted word, drained one lane per output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_last_q <= 1'b0;
            hold_user_q <= 1'b0;
            hold_vld_q  <= 1'b0;
        end else if (load_hold) begin
            hold_data_q <= s_axis_tdata;
            hold_keep_q <= s_axis_tkeep;
            hold_last_q <= s_axis_tlast;
            hold_user_q <= s_axis_tuser[0];
            hold_vld_q  <= 1'b1;
        end else begin
            if (m_hs)               hold_keep_q <= rest;
            if (final_hs | marker)  hold_vld_q  <= 1'b0;
        end
    end

    // Header capture: word0 is staged so a truncated record never disturbs hdr_*.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_stage_q  <= '0;
            hdr_ts_q    <= '0;
            hdr_len_q   <= '0;
            hdr_valid_q <= 1'b0;
            err_trunc_q <= 1'b0;
        end else begin
            if (load_ts) ts_stage_q <= s_axis_tdata;
            if (load_hdr) begin
                hdr_ts_q  <= ts_stage_q;
                hdr_len_q <= s_axis_tdata[FRAME_LEN_WIDTH-1:0];
            end
            hdr_valid_q <= load_hdr;
            err_trunc_q <= trunc;
        end
    end

    // Per-record byte counter and completed-record counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (state_q == ST_TS) byte_cnt_q <= '0;
            else if (m_hs)        byte_cnt_q <= byte_cnt_inc;
            if (close_byte | close_marker) frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

`ifdef PCAP_DEFRAMER_LEN_CHECK_EN
    logic err_len_q;
    logic byte_mismatch;
    logic marker_mismatch;

    assign byte_mismatch   = byte_cnt_inc != hdr_len_q;
    assign marker_mismatch = byte_cnt_q != hdr_len_q;

    // Length mismatch pulse at record close.
    always_ff @(posedge clk) begin
        if (rst) err_len_q <= 1'b0;
        else     err_len_q <= (close_byte & byte_mismatch) | (close_marker & marker_mismatch);
    end

    assign m_axis_tuser     = last_byte & (hold_user_q | byte_mismatch);
    assign err_len_mismatch = err_len_q;
`else
    assign m_axis_tuser = last_byte & hold_user_q;
`endif

    assign m_axis_tdata  = m_byte;
    assign m_axis_tvalid = byte_avail;
    assign m_axis_tlast  = last_byte;
    assign hdr_ts_sec    = hdr_ts_q[31:0];
    assign hdr_ts_nsec   = hdr_ts_q[63:32];
    assign hdr_frame_len = hdr_len_q;
    assign hdr_valid     = hdr_valid_q;
    assign err_truncated = err_trunc_q;
    assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_pcap_axis_deframer.sv
// tb_pcap_axis_deframer: randomized records checked against a byte-queue model of the deframer.
// Works with or without PCAP_DEFRAMER_LEN_CHECK_EN defined.
module tb_pcap_axis_deframer;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
    } exp_t;

    typedef struct {
        logic [31:0] s;
        logic [31:0] n;
        logic [15:0] len;
    } hexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [0:0]  s_tuser = '0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        m_tuser;
    logic [31:0] hdr_ts_sec;
    logic [31:0] hdr_ts_nsec;
    logic [15:0] hdr_frame_len;
    logic        hdr_valid;
    logic        err_truncated;
    logic [31:0] frame_count;
`ifdef PCAP_DEFRAMER_LEN_CHECK_EN
    logic        err_len;
`endif

    pcap_axis_deframer dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .hdr_ts_sec    (hdr_ts_sec),
        .hdr_ts_nsec   (hdr_ts_nsec),
        .hdr_frame_len (hdr_frame_len),
        .hdr_valid     (hdr_valid),
        .err_truncated (err_truncated),
        .frame_count   (frame_count)
`ifdef PCAP_DEFRAMER_LEN_CHECK_EN
        ,
        .err_len_mismatch (err_len)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;
    bit gap_on = 0;

    exp_t        exq[$];
    hexp_t       hq[$];
    logic [7:0]  cap[$];
    logic [63:0] rec_d[$];
    logic [7:0]  rec_k[$];

    int   frame_exp = 0;
    int   trunc_exp = 0;
    int   trunc_seen = 0;
    int   errlen_exp = 0;
    int   errlen_seen = 0;
    int   hdr_seen = 0;
    int   rec_bytes = 0;
    int   last_rec_bytes = 0;
    logic last_tuser = 1'b0;
    bit   stab_pending = 0;
    logic [10:0] stab_word = '0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic abort(input string name);
        errors++;
        checks++;
        $display("FAIL %s: timed out", name);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "bench stopped");
    endtask

    initial begin
        #3000000;
        abort("watchdog");
    end

    // Downstream ready pattern: always, alternating, or random.
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = ($urandom_range(0, 9) < 7);
        endcase
    end

    // Compare process: every output byte, header pulse and error pulse against the model.
    always @(negedge clk) begin
        exp_t  e;
        hexp_t h;
        if (rst) begin
            stab_pending = 0;
        end else begin
            if (stab_pending) begin
                check_eq("m_hold_stable", {m_tvalid, m_tlast, m_tuser, m_tdata}, stab_word);
                stab_pending = 0;
            end
            if (m_tvalid && m_tready) begin
                if (exq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", m_tdata);
                end else begin
                    e = exq.pop_front();
                    check_eq("byte", {m_tlast, m_tuser, m_tdata}, {e.l, e.u, e.d});
                    cap.push_back(m_tdata);
                    rec_bytes++;
                    if (m_tlast) begin
                        last_rec_bytes = rec_bytes;
                        last_tuser = m_tuser;
                        rec_bytes = 0;
                    end
                end
            end else if (m_tvalid) begin
                stab_pending = 1;
                stab_word = {1'b1, m_tlast, m_tuser, m_tdata};
            end
            if (hdr_valid) begin
                hdr_seen++;
                if (hq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hdr: got len %0d expected none", hdr_frame_len);
                end else begin
                    h = hq.pop_front();
                    check_eq("hdr", {hdr_ts_nsec, hdr_ts_sec, hdr_frame_len}, {h.n, h.s, h.len});
                end
            end
            if (err_truncated) trunc_seen++;
`ifdef PCAP_DEFRAMER_LEN_CHECK_EN
            if (err_len) errlen_seen++;
`endif
        end
    end

    task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        int n;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_tready) begin
            n++;
            if (n > 2000) abort("s_tready_wait");
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (gap_on && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [63:0] d, input logic [7:0] k);
        rec_d.push_back(d);
        rec_k.push_back(k);
    endtask

    task automatic push_t1_payload();
        logic [63:0] d;
        for (int w = 0; w < 8; w++) begin
            for (int l = 0; l < 8; l++) d[l*8 +: 8] = 8'(w * 8 + l);
            push_word(d, 8'hFF);
        end
    endtask

    // Model: expected bytes are the set lanes of each word in order; tlast/tuser on the
    // final set lane of the tlast word; a record with no bytes counts as truncated.
    task automatic send_record(input logic [31:0] sec, input logic [31:0] nsec,
                               input logic [15:0] len, input logic u, input bit open_rec);
        int          nb;
        int          last_w;
        exp_t        e;
        hexp_t       h;
        logic [63:0] t;
        logic [7:0]  tk;
        logic [63:0] w1;
        logic        mism;
        nb = 0;
        last_w = rec_d.size() - 1;
        for (int w = 0; w <= last_w; w++) begin
            t  = rec_d[w];
            tk = rec_k[w];
            for (int l = 0; l < 8; l++) begin
                if (tk[l]) begin
                    e.d = t[l*8 +: 8];
                    e.l = 1'b0;
                    e.u = 1'b0;
                    exq.push_back(e);
                    nb++;
                end
            end
        end
`ifdef PCAP_DEFRAMER_LEN_CHECK_EN
        mism = (nb != int'(len));
`else
        mism = 1'b0;
`endif
        tk = rec_k[last_w];
        if (!open_rec && nb > 0 && tk != 8'h00) begin
            e = exq.pop_back();
            e.l = 1'b1;
            e.u = u | mism;
            exq.push_back(e);
        end
        if (!open_rec) begin
            if (nb > 0) begin
                frame_exp++;
                if (mism) errlen_exp++;
            end else begin
                trunc_exp++;
            end
        end
        h.s = sec;
        h.n = nsec;
        h.len = len;
        hq.push_back(h);
        send_word({nsec, sec}, 8'($urandom), 1'b0, 1'b0);
        w1 = {$urandom, $urandom};
        w1[15:0] = len;
        send_word(w1, 8'($urandom), 1'b0, 1'b0);
        for (int w = 0; w <= last_w; w++) begin
            send_word(rec_d[w], rec_k[w], !open_rec && w == last_w,
                      (w == last_w) ? u : 1'($urandom_range(0, 1)));
        end
        rec_d.delete();
        rec_k.delete();
    endtask

    task automatic send_trunc(input bit on_w1);
        trunc_exp++;
        if (!on_w1) begin
            send_word({$urandom, $urandom}, 8'hFF, 1'b1, 1'b0);
        end else begin
            send_word({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
            send_word({$urandom, $urandom}, 8'hFF, 1'b1, 1'b0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exq.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 5000) abort("drain");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int          nw;
        int          cnt;
        logic [7:0]  k;
        logic [15:0] len;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_s_tready", s_tready, 0);
        check_eq("rst_m_tvalid", m_tvalid, 0);
        check_eq("rst_outputs", {m_tlast, m_tuser, hdr_valid, err_truncated}, 0);
        check_eq("rst_hdr", {hdr_ts_sec, hdr_ts_nsec, hdr_frame_len}, 0);
        check_eq("rst_frame_count", frame_count, 0);
        rst = 1'b0;

        // T1: 64-byte record, full-rate downstream
        cap.delete();
        push_t1_payload();
        send_record(32'd10, 32'd100, 16'd64, 1'b0, 0);
        drain();
        check_eq("t1_nbytes", cap.size(), 64);
        check_eq("t1_last_rec_bytes", last_rec_bytes, 64);
        check_eq("t1_byte63", cap[63], 8'd63);
        check_eq("t1_ts_sec", hdr_ts_sec, 32'd10);
        check_eq("t1_ts_nsec", hdr_ts_nsec, 32'd100);
        check_eq("t1_len", hdr_frame_len, 16'd64);
        check_eq("t1_hdr_pulses", hdr_seen, 1);
        check_eq("t1_frame_count", frame_count, 32'd1);

        // T2: partial final word, 59 bytes
        for (int w = 0; w < 7; w++) push_word({$urandom, $urandom}, 8'hFF);
        push_word({$urandom, $urandom}, 8'h07);
        send_record(32'd11, 32'd200, 16'd59, 1'b0, 0);
        drain();
        check_eq("t2_last_rec_bytes", last_rec_bytes, 59);

        // T2: sparse keep 0xA5
        cap.delete();
        push_word(64'h0706050403020100, 8'hA5);
        send_record(32'd1, 32'd2, 16'd4, 1'b0, 0);
        drain();
        check_eq("a5_nbytes", cap.size(), 4);
        check_eq("a5_lanes", {cap[0], cap[1], cap[2], cap[3]}, 32'h00020507);

        // T3: alternating downstream ready
        rdy_mode = 1;
        cap.delete();
        push_t1_payload();
        send_record(32'd10, 32'd100, 16'd64, 1'b0, 0);
        drain();
        check_eq("t3_nbytes", cap.size(), 64);
        check_eq("t3_byte20", cap[20], 8'd20);

        // T4: truncation on word1 and on word0, then a good record
        rdy_mode = 0;
        send_trunc(1);
        send_trunc(0);
        push_t1_payload();
        send_record(32'd10, 32'd100, 16'd64, 1'b0, 0);
        drain();
        check_eq("t4_trunc_pulses", trunc_seen, 2);
        check_eq("t4_frame_count", frame_count, 32'd5);

        // T5: input tuser propagates to last byte
        push_t1_payload();
        send_record(32'd3, 32'd4, 16'd64, 1'b1, 0);
        drain();
        check_eq("t5_tuser", last_tuser, 1'b1);

        // T5: length field 60 with 64 bytes sent
        push_t1_payload();
        send_record(32'd5, 32'd6, 16'd60, 1'b0, 0);
        drain();
`ifdef PCAP_DEFRAMER_LEN_CHECK_EN
        check_eq("t5_len_tuser", last_tuser, 1'b1);
        check_eq("t5_errlen", errlen_seen, 1);
`else
        check_eq("t5_len_tuser", last_tuser, 1'b0);
`endif

        // tlast on an empty word after bytes closes the record; on the first word truncates
        push_word({$urandom, $urandom}, 8'hFF);
        push_word({$urandom, $urandom}, 8'hFF);
        push_word({$urandom, $urandom}, 8'h00);
        send_record(32'd7, 32'd8, 16'd16, 1'b0, 0);
        drain();
        check_eq("tail_empty_count", frame_count, 32'd8);
        push_word({$urandom, $urandom}, 8'h00);
        send_record(32'd9, 32'd9, 16'd0, 1'b0, 0);
        drain();
        check_eq("empty_first_trunc", trunc_seen, 3);
        check_eq("empty_first_count", frame_count, 32'd8);

        // Random records with random ready, gaps and occasional truncations
        rdy_mode = 2;
        gap_on = 1;
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 9) == 0) begin
                send_trunc(1'($urandom_range(0, 1)));
            end else begin
                nw = $urandom_range(1, 6);
                cnt = 0;
                for (int w = 0; w < nw; w++) begin
                    k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
                    if (w == nw - 1 && k == 8'h00) k = 8'h80;
                    cnt += $countones(k);
                    push_word({$urandom, $urandom}, k);
                end
                if ($urandom_range(0, 7) == 0) push_word({$urandom, $urandom}, 8'h00);
                len = 16'(cnt + (($urandom_range(0, 3) == 0) ? 1 : 0));
                send_record($urandom, $urandom, len, 1'($urandom_range(0, 1)), 0);
            end
        end
        drain();
        check_eq("rand_frame_count", frame_count, frame_exp);
        check_eq("rand_trunc", trunc_seen, trunc_exp);

        // T6: reset at byte 20 of an open record
        rdy_mode = 0;
        gap_on = 0;
        cap.delete();
        for (int w = 0; w < 3; w++) push_word({$urandom, $urandom}, 8'hFF);
        send_record(32'd20, 32'd21, 16'd64, 1'b0, 1);
        n = 0;
        while (cap.size() < 20) begin
            @(negedge clk);
            n++;
            if (n > 500) abort("t6_byte20");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_m_tvalid", m_tvalid, 0);
        check_eq("t6_s_tready", s_tready, 0);
        check_eq("t6_outputs", {m_tlast, m_tuser, hdr_valid, err_truncated}, 0);
        check_eq("t6_hdr", {hdr_ts_sec, hdr_ts_nsec, hdr_frame_len}, 0);
        check_eq("t6_frame_count", frame_count, 0);
        rst = 1'b0;
        exq.delete();
        hq.delete();
        rec_bytes = 0;
        frame_exp = 0;
        cap.delete();
        push_t1_payload();
        send_record(32'd10, 32'd100, 16'd64, 1'b0, 0);
        drain();
        check_eq("t6_after_nbytes", cap.size(), 64);
        check_eq("t6_after_count", frame_count, 32'd1);

        check_eq("end_exq_empty", exq.size(), 0);
        check_eq("end_hq_empty", hq.size(), 0);
        check_eq("end_trunc", trunc_seen, trunc_exp);
        check_eq("end_errlen", errlen_seen, errlen_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
